// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: blanked one-hot digit scan with a frame-aligned valid/ready update (clk, rst, i_data/i_valid/o_ready in; o_nibble, o_digit_en, o_frame_done out)
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter bit DIGIT_EN_ACTIVE_HIGH = 1'b0,
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [3:0]              o_nibble,
  output logic [NUM_DIGITS-1:0]   o_digit_en,
  output logic                    o_frame_done
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] P_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] P_BLANK = CW'(BLANK_CYCLES);
  localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EN_OFF = DIGIT_EN_ACTIVE_HIGH ? '0 : '1;
  typedef enum logic {S_BLANK, S_DRIVE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DW-1:0] dig, dig_n;
  logic [4*NUM_DIGITS-1:0] active, active_n, shadow;
  logic capture, commit, lz_off, fd_n;
  logic [3:0] nib_n;
  logic [NUM_DIGITS-1:0] en_n;
  assign capture = i_valid && o_ready;
  assign commit = o_frame_done && !o_ready;
  assign active_n = commit ? shadow : active;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_BLANK;
      cnt <= '0;
      dig <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dig <= dig_n;
    end
  end
  always_comb begin
    cnt_n = cnt == P_LAST ? '0 : cnt + 1'b1;
    dig_n = cnt != P_LAST ? dig : dig == D_LAST ? '0 : dig + 1'b1;
    state_n = cnt_n < P_BLANK ? S_BLANK : S_DRIVE;
  end
  always_comb begin
    lz_off = LZ_BLANK && dig_n != '0 && (active_n >> {dig_n, 2'b00}) == '0;
    nib_n = active_n[{dig_n, 2'b00} +: 4];
    en_n = (state_n == S_DRIVE && !lz_off) ? NUM_DIGITS'(1) << dig_n : '0;
    fd_n = dig_n == D_LAST && cnt_n == P_LAST;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= '0;
      shadow <= '0;
      o_ready <= 1'b1;
      o_nibble <= '0;
      o_digit_en <= EN_OFF;
      o_frame_done <= 1'b0;
    end else begin
      active <= active_n;
      shadow <= capture ? i_data : shadow;
      o_ready <= capture ? 1'b0 : commit ? 1'b1 : o_ready;
      o_nibble <= nib_n;
      o_digit_en <= en_n ^ EN_OFF;
      o_frame_done <= fd_n;
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: randomized scan/handshake checks against a cycle-count reference model
module tb_seven_seg_scan_ctrl;
  localparam int N = 4, DIV = 8, BL = 2;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0;
  logic [15:0] data = '0;
  logic rdy0, rdy1, fd0, fd1;
  logic [3:0] nib0, nib1, en0, en1;
  int vec = 0, err = 0, c = 0;
  logic [15:0] m_act = '0, m_sh = '0;
  bit m_pend = 0;
  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BL),
    .DIGIT_EN_ACTIVE_HIGH(1'b1), .LZ_BLANK(1'b0)) u0 (.clk(clk), .rst(rst),
    .i_data(data), .i_valid(valid), .o_ready(rdy0), .o_nibble(nib0),
    .o_digit_en(en0), .o_frame_done(fd0));
  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BL),
    .DIGIT_EN_ACTIVE_HIGH(1'b1), .LZ_BLANK(1'b1)) u1 (.clk(clk), .rst(rst),
    .i_data(data), .i_valid(valid), .o_ready(rdy1), .o_nibble(nib1),
    .o_digit_en(en1), .o_frame_done(fd1));
  always #5 clk = ~clk;
  function automatic int m_d();
    return (c / DIV) % N;
  endfunction
  function automatic logic [3:0] m_nib();
    return 4'(m_act >> (4 * m_d()));
  endfunction
  function automatic logic m_fd();
    return m_d() == N - 1 && c % DIV == DIV - 1;
  endfunction
  function automatic logic [3:0] m_en(input bit lz);
    if (c % DIV < BL) return 4'b0;
    if (lz && m_d() > 0 && (m_act >> (4 * m_d())) == 0) return 4'b0;
    return 4'(1 << m_d());
  endfunction
  task automatic cyc(input logic [15:0] dv, input bit v);
    bit fdn, cap, com;
    data = dv;
    valid = v;
    @(posedge clk);
    fdn = m_fd();
    cap = v && !m_pend;
    com = fdn && m_pend;
    if (com) begin m_act = m_sh; m_pend = 0; end
    if (cap) begin m_sh = dv; m_pend = 1; end
    c++;
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    valid = 1'b0;
    @(posedge clk);
    #1;
    m_act = '0; m_sh = '0; m_pend = 0; c = 0;
  endtask
  task automatic test_reset();
    do_reset();
    vec++; if (nib0 !== 4'h0) begin err++; $display("FAIL reset_nibble got %h want 0", nib0); end
    vec++; if (en0 !== 4'b0000 || en1 !== 4'b0000) begin err++; $display("FAIL reset_en got %b/%b want 0000", en0, en1); end
    vec++; if (fd0 !== 1'b0) begin err++; $display("FAIL reset_frame_done got %b want 0", fd0); end
    vec++; if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin err++; $display("FAIL reset_ready got %b/%b want 1", rdy0, rdy1); end
    rst = 1'b0;
  endtask
  task automatic test_scan();
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 70; i++) begin
      vec++; if (nib0 !== 4'h0) begin err++; $display("FAIL scan_nibble c=%0d got %h want 0", c, nib0); end
      vec++; if (en0 !== m_en(0)) begin err++; $display("FAIL scan_en c=%0d got %b want %b", c, en0, m_en(0)); end
      vec++; if (en1 !== m_en(1)) begin err++; $display("FAIL scan_en_lz c=%0d got %b want %b", c, en1, m_en(1)); end
      vec++; if (fd0 !== m_fd()) begin err++; $display("FAIL scan_frame_done c=%0d got %b want %b", c, fd0, m_fd()); end
      if (c == 10) begin vec++; if (en0 !== 4'b0010) begin err++; $display("FAIL scan_en_c10 got %b want 0010", en0); end end
      cyc(16'($urandom), 1'b0);
    end
  endtask
  task automatic test_handshake();
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 72; i++) begin
      vec++; if (rdy0 !== !m_pend) begin err++; $display("FAIL hs_ready c=%0d got %b want %b", c, rdy0, !m_pend); end
      vec++; if (nib0 !== m_nib()) begin err++; $display("FAIL hs_nibble c=%0d got %h want %h", c, nib0, m_nib()); end
      vec++; if (en0 !== m_en(0)) begin err++; $display("FAIL hs_en c=%0d got %b want %b", c, en0, m_en(0)); end
      if (c == 40) begin vec++; if (nib0 !== 4'hC) begin err++; $display("FAIL hs_nibble_c40 got %h want c", nib0); end end
      if (c == 31) begin vec++; if (nib0 !== 4'h0 || rdy0 !== 1'b0) begin err++; $display("FAIL hs_c31 got %h/%b want 0/0", nib0, rdy0); end end
      if (c == 58) begin vec++; if (nib0 !== 4'hA) begin err++; $display("FAIL hs_nibble_c58 got %h want a", nib0); end end
      cyc(c == 5 ? 16'hA3C5 : (c > 5 && c < 32) ? 16'hFFFF : 16'($urandom), c >= 5 && c < 32);
    end
  endtask
  task automatic test_boundary();
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 72; i++) begin
      vec++; if (rdy0 !== !m_pend) begin err++; $display("FAIL bnd_ready c=%0d got %b want %b", c, rdy0, !m_pend); end
      vec++; if (nib0 !== m_nib()) begin err++; $display("FAIL bnd_nibble c=%0d got %h want %h", c, nib0, m_nib()); end
      if (c == 63) begin vec++; if (nib0 !== 4'h0 || rdy0 !== 1'b0) begin err++; $display("FAIL bnd_c63 got %h/%b want 0/0", nib0, rdy0); end end
      if (c == 64) begin vec++; if (nib0 !== 4'h4 || rdy0 !== 1'b1) begin err++; $display("FAIL bnd_c64 got %h/%b want 4/1", nib0, rdy0); end end
      cyc(c == 31 ? 16'h1234 : 16'($urandom), c == 31);
    end
  endtask
  task automatic test_lz();
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 130; i++) begin
      vec++; if (en1 !== m_en(1)) begin err++; $display("FAIL lz_en c=%0d got %b want %b", c, en1, m_en(1)); end
      vec++; if (nib1 !== m_nib()) begin err++; $display("FAIL lz_nibble c=%0d got %h want %h", c, nib1, m_nib()); end
      if (c == 42) begin vec++; if (en1 !== 4'b0010) begin err++; $display("FAIL lz_c42 got %b want 0010", en1); end end
      if (c == 58) begin vec++; if (en1 !== 4'b0000 || en0 !== 4'b1000) begin err++; $display("FAIL lz_c58 got %b/%b want 0000/1000", en1, en0); end end
      if (c == 106) begin vec++; if (en1 !== 4'b0000) begin err++; $display("FAIL lz_c106 got %b want 0000", en1); end end
      cyc(c == 1 ? 16'h0070 : c == 64 ? 16'h0000 : 16'($urandom), c == 1 || c == 64);
    end
  endtask
  task automatic test_rst_mid();
    do_reset();
    rst = 1'b0;
    while (c < 45) cyc(c == 35 ? 16'h9876 : 16'($urandom), c == 35);
    do_reset();
    vec++; if (rdy0 !== 1'b1 || en0 !== 4'b0000 || nib0 !== 4'h0 || fd0 !== 1'b0) begin
      err++; $display("FAIL rstmid_outputs got rdy=%b en=%b nib=%h fd=%b want 1/0000/0/0", rdy0, en0, nib0, fd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      vec++; if (nib0 !== 4'h0 || rdy0 !== 1'b1) begin err++; $display("FAIL rstmid_after c=%0d got %h/%b want 0/1", c, nib0, rdy0); end
      vec++; if (en0 !== m_en(0)) begin err++; $display("FAIL rstmid_en c=%0d got %b want %b", c, en0, m_en(0)); end
      cyc(16'($urandom), 1'b0);
    end
  endtask
  task automatic test_back_to_back();
    do_reset();
    rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      vec++; if (nib0 !== m_nib() || nib1 !== m_nib()) begin err++; $display("FAIL b2b_nibble c=%0d got %h/%h want %h", c, nib0, nib1, m_nib()); end
      vec++; if (en0 !== m_en(0) || en1 !== m_en(1)) begin err++; $display("FAIL b2b_en c=%0d got %b/%b want %b/%b", c, en0, en1, m_en(0), m_en(1)); end
      vec++; if (rdy0 !== !m_pend || rdy1 !== !m_pend) begin err++; $display("FAIL b2b_ready c=%0d got %b/%b want %b", c, rdy0, rdy1, !m_pend); end
      vec++; if (fd0 !== m_fd() || fd1 !== m_fd()) begin err++; $display("FAIL b2b_frame_done c=%0d got %b/%b want %b", c, fd0, fd1, m_fd()); end
      cyc(($urandom % 3 == 0) ? 16'($urandom) & 16'h0F0F : 16'($urandom), $urandom % 4 == 0);
    end
  endtask
  initial begin
    test_reset();
    test_scan();
    test_handshake();
    test_boundary();
    test_lz();
    test_rst_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
